// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmitter: the FSM state encoding and a
// parity helper. The optional parity stage is compiled in only when the macro
// UART_PARITY_EN is defined; the state encoding stays the same either way so
// that state values read identically in both builds.
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // Widest data word the transmitter supports; the parity helper works on
    // this width and callers zero-extend narrower words.
    localparam int MAX_DATA_WIDTH = 9;

    // Transmitter states, in frame order. ST_PARITY is only ever entered when
    // the parity stage is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    // Zero-extension of narrow words does not change the result.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// -----------------------------------------------------------------------------
// uart_tick_detect
// Registers the baud-rate square wave and produces a one-clock pulse on each
// of its rising edges. The baud wave is generated from the same system clock,
// so it is sampled directly without a synchroniser.
//
// Ports
//   clock    in  system clock
//   reset    in  asynchronous, active-high reset
//   i_u_clk  in  baud-rate square wave
//   o_tick   out one-cycle pulse, high while i_u_clk is high and was low last cycle
// -----------------------------------------------------------------------------
module uart_tick_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_u_clk,
    output logic o_tick
);

    logic u_clk_q;

    // Remember last cycle's level of the baud wave so a rising edge can be
    // recognised combinationally in the current cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            u_clk_q <= 1'b0;
        end else begin
            u_clk_q <= i_u_clk;
        end
    end

    assign o_tick = i_u_clk & ~u_clk_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Accepts one parallel word per valid/ready handshake
// and sends it as a start bit, the data bits LSB first, an optional parity bit
// and P_STOP_BITS stop bits. Every bit boundary is a rising edge of i_u_clk;
// o_tx changes on the clock after the cycle in which that edge is seen.
//
// Configuration macro: UART_PARITY_EN
//   defined   - a parity bit (even or odd per P_PARITY_ODD) follows the data
//   undefined - no parity stage; P_PARITY_ODD has no effect
//
// Parameters
//   P_DATA_WIDTH  data bits per frame (5..9)
//   P_STOP_BITS   stop bits per frame (1 or 2)
//   P_PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clock       in  system clock
//   reset       in  asynchronous, active-high reset; aborts any frame
//   i_u_clk     in  baud-rate square wave from the baud generator
//   i_tx_data   in  word to send
//   i_tx_valid  in  i_tx_data is valid
//   o_tx_ready  out a word can be accepted this cycle
//   o_tx        out serial line, idles high
//   o_tx_busy   out frame in progress
//   o_tx_done   out one-cycle pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_STOP_BITS  = 1,
    parameter int P_PARITY_ODD = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_u_clk,
    input  logic [P_DATA_WIDTH-1:0] i_tx_data,
    input  logic                    i_tx_valid,
    output logic                    o_tx_ready,
    output logic                    o_tx,
    output logic                    o_tx_busy,
    output logic                    o_tx_done
);

    localparam int BIT_CNT_W = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(P_DATA_WIDTH - 1);
    localparam logic [1:0]           LAST_STOP = 2'(P_STOP_BITS - 1);

    logic                    tick;
    tx_state_e               state_q;
    logic [P_DATA_WIDTH-1:0] shift_q;
    logic [BIT_CNT_W-1:0]    bit_cnt_q;
    logic [1:0]              stop_cnt_q;
    logic                    tx_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
`ifdef UART_PARITY_EN
    logic                    par_q;
`endif

    uart_tick_detect u_tick_detect (
        .clock   (clock),
        .reset   (reset),
        .i_u_clk (i_u_clk),
        .o_tick  (tick)
    );

    // Whole frame sequencer. All outputs are registered here so the serial
    // line only ever changes on the clock after a baud tick. WAIT exists so
    // that a tick landing on the accept cycle is ignored and the start bit
    // always begins on a clean bit boundary. bit_cnt stops at the last data
    // bit instead of wrapping, and the shift register keeps the next bit to
    // send in position 0. done is a pulse, so it falls back to 0 by default.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_tx_valid && ready_q) begin
                        shift_q <= i_tx_data;
`ifdef UART_PARITY_EN
                        par_q   <= calc_parity(MAX_DATA_WIDTH'(i_tx_data), P_PARITY_ODD != 0);
`endif
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= ST_PARITY;
`else
                            tx_q       <= 1'b1;
                            stop_cnt_q <= '0;
                            state_q    <= ST_STOP;
`endif
                        end else begin
                            shift_q   <= {1'b0, shift_q[P_DATA_WIDTH-1:1]};
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= '0;
                        state_q    <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_q == LAST_STOP) begin
                            stop_cnt_q <= '0;
                            done_q     <= 1'b1;
                            ready_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = ready_q;
    assign o_tx_busy  = busy_q;
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Two instances share clock, reset and a
// divide-by-16 baud wave: dutA sends 8 data bits with 1 stop bit and even
// parity, dutB sends 8 data bits with 2 stop bits and odd parity. Parity bits
// appear on the line only when UART_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       expPar;
    } vec_t;

`ifdef UART_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    localparam int BAUD_DIV = 16;
    localparam int NUM_VECS = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       uClk;
    int         baudCnt;
    logic [7:0] dataA, dataB;
    logic       validA, validB;
    logic       readyA, txA, busyA, doneA;
    logic       readyB, txB, busyB, doneB;
    int         doneCntA = 0;
    int         doneCntB = 0;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs [NUM_VECS];

    uart_tx #(.P_DATA_WIDTH(8), .P_STOP_BITS(1), .P_PARITY_ODD(0)) dutA (
        .clock      (clock),
        .reset      (reset),
        .i_u_clk    (uClk),
        .i_tx_data  (dataA),
        .i_tx_valid (validA),
        .o_tx_ready (readyA),
        .o_tx       (txA),
        .o_tx_busy  (busyA),
        .o_tx_done  (doneA)
    );

    uart_tx #(.P_DATA_WIDTH(8), .P_STOP_BITS(2), .P_PARITY_ODD(1)) dutB (
        .clock      (clock),
        .reset      (reset),
        .i_u_clk    (uClk),
        .i_tx_data  (dataB),
        .i_tx_valid (validB),
        .o_tx_ready (readyB),
        .o_tx       (txB),
        .o_tx_busy  (busyB),
        .o_tx_done  (doneB)
    );

    // 100 MHz-style system clock, period 10.
    always #5 clock = ~clock;

    // Baud generator: low for 8 clocks, high for 8, changing away from the
    // active edge so every rising edge is one clean tick.
    initial begin
        baudCnt = 0;
        uClk    = 1'b0;
        forever begin
            @(negedge clock);
            baudCnt = (baudCnt + 1) % BAUD_DIV;
            uClk    = (baudCnt >= BAUD_DIV / 2);
        end
    end

    // Count done pulses so stray or missing pulses show up as a count error.
    always @(negedge clock) begin
        if (doneA) doneCntA <= doneCntA + 1;
        if (doneB) doneCntB <= doneCntB + 1;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic getTx(input int sel);
        return (sel == 0) ? txA : txB;
    endfunction

    function automatic logic getReady(input int sel);
        return (sel == 0) ? readyA : readyB;
    endfunction

    function automatic logic getBusy(input int sel);
        return (sel == 0) ? busyA : busyB;
    endfunction

    function automatic logic getDone(input int sel);
        return (sel == 0) ? doneA : doneB;
    endfunction

    function automatic int getDoneCnt(input int sel);
        return (sel == 0) ? doneCntA : doneCntB;
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            validA = v;
            dataA  = d;
        end else begin
            validB = v;
            dataB  = d;
        end
    endtask

    // Expected line levels for one frame: start, data LSB first, optional
    // parity, then the stop bits.
    task automatic buildFrame(input logic [7:0] d, input logic p, input int stops,
                              output logic [15:0] bits, output int n);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
        if (PARITY_ON) begin
            bits[9] = p;
            n = 10;
        end
        for (int s = 0; s < stops; s++) begin
            bits[n] = 1'b1;
            n++;
        end
    endtask

    // Waits (bounded) for the start bit, then checks every clock of every
    // bit, the done pulse, and the return to idle. Returns at the negedge
    // after the done pulse; gap is the number of negedges waited for the
    // start bit.
    task automatic captureFrame(input int sel, input logic [7:0] d, input logic p,
                                output int gap);
        logic [15:0] bits;
        int          n;
        int          bad;
        int          doneBefore;
        int          stops;
        stops = (sel == 0) ? 1 : 2;
        buildFrame(d, p, stops, bits, n);
        doneBefore = getDoneCnt(sel);
        gap = 0;
        while (getTx(sel) !== 1'b0 && gap < 64) begin
            @(negedge clock);
            gap++;
        end
        if (getTx(sel) !== 1'b0) begin
            checkOutput($sformatf("dut%0d start bit timeout", sel), getTx(sel), 1'b0);
            return;
        end
        for (int b = 0; b < n; b++) begin
            bad = 0;
            for (int c = 0; c < BAUD_DIV; c++) begin
                if (getTx(sel) !== bits[b]) bad++;
                @(negedge clock);
            end
            checkInt($sformatf("dut%0d data %02h bit%0d wrong cycles", sel, d, b), bad, 0);
        end
        checkOutput($sformatf("dut%0d done pulse", sel), getDone(sel), 1'b1);
        checkOutput($sformatf("dut%0d ready after frame", sel), getReady(sel), 1'b1);
        checkOutput($sformatf("dut%0d busy after frame", sel), getBusy(sel), 1'b0);
        checkOutput($sformatf("dut%0d line idle after frame", sel), getTx(sel), 1'b1);
        @(negedge clock);
        checkOutput($sformatf("dut%0d done one cycle", sel), getDone(sel), 1'b0);
        checkInt($sformatf("dut%0d done count", sel), getDoneCnt(sel) - doneBefore, 1);
    endtask

    // Full handshake plus frame check for one word.
    task automatic sendFrame(input int sel, input logic [7:0] d, input logic p);
        int gap;
        applyStimulus(sel, 1'b1, d);
        @(negedge clock);
        checkOutput($sformatf("dut%0d ready low after accept", sel), getReady(sel), 1'b0);
        checkOutput($sformatf("dut%0d busy high after accept", sel), getBusy(sel), 1'b1);
        applyStimulus(sel, 1'b0, ~d);
        captureFrame(sel, d, p, gap);
        checkOutput($sformatf("dut%0d start latency %0d in range", sel, gap),
                    (gap >= 1 && gap <= BAUD_DIV), 1'b1);
    endtask

    initial begin
        int gap;
        int bad;

        // Hand-computed parity: dutA even, dutB odd.
        vecs[0] = '{0, 8'h55, 1'b0};
        vecs[1] = '{0, 8'hA3, 1'b0};
        vecs[2] = '{0, 8'h00, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0};
        vecs[4] = '{0, 8'h01, 1'b1};
        vecs[5] = '{0, 8'h80, 1'b1};
        vecs[6] = '{0, 8'h7E, 1'b0};
        vecs[7] = '{1, 8'hA3, 1'b1};
        vecs[8] = '{1, 8'h0F, 1'b1};
        vecs[9] = '{1, 8'h07, 1'b0};

        reset = 1'b1;
        applyStimulus(0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 8'h00);
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("dut%0d reset tx", s), getTx(s), 1'b1);
            checkOutput($sformatf("dut%0d reset ready", s), getReady(s), 1'b1);
            checkOutput($sformatf("dut%0d reset busy", s), getBusy(s), 1'b0);
            checkOutput($sformatf("dut%0d reset done", s), getDone(s), 1'b0);
        end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("dutA idle line after reset", txA, 1'b1);
        checkOutput("dutB idle line after reset", txB, 1'b1);

        $display("[TB] table-driven frames");
        for (int v = 0; v < NUM_VECS; v++) begin
            sendFrame(vecs[v].sel, vecs[v].data, vecs[v].expPar);
            repeat (5) @(negedge clock);
        end

        $display("[TB] back-to-back with valid held high");
        applyStimulus(0, 1'b1, 8'h00);
        @(negedge clock);
        checkOutput("b2b first accept", readyA, 1'b0);
        applyStimulus(0, 1'b1, 8'hFF);
        captureFrame(0, 8'h00, 1'b0, gap);
        checkOutput("b2b second accept ready", readyA, 1'b0);
        checkOutput("b2b second accept busy", busyA, 1'b1);
        applyStimulus(0, 1'b0, 8'h00);
        captureFrame(0, 8'hFF, 1'b0, gap);
        // Capture began one negedge after the done pulse.
        checkInt("b2b start after previous stop end", gap + 1, BAUD_DIV);

        $display("[TB] valid pulse while busy");
        repeat (7) @(negedge clock);
        applyStimulus(0, 1'b1, 8'h55);
        @(negedge clock);
        applyStimulus(0, 1'b0, 8'h55);
        fork
            captureFrame(0, 8'h55, 1'b0, gap);
            begin
                repeat (40) @(negedge clock);
                applyStimulus(0, 1'b1, 8'h12);
                @(negedge clock);
                applyStimulus(0, 1'b0, 8'h12);
            end
        join
        bad = 0;
        for (int c = 0; c < 3 * BAUD_DIV; c++) begin
            if (txA !== 1'b1 || busyA !== 1'b0) bad++;
            @(negedge clock);
        end
        checkInt("ignored word caused activity cycles", bad, 0);

        $display("[TB] reset during data bit 3");
        applyStimulus(1, 1'b1, 8'hA5);
        @(negedge clock);
        applyStimulus(1, 1'b0, 8'h00);
        gap = 0;
        while (txB !== 1'b0 && gap < 64) begin
            @(negedge clock);
            gap++;
        end
        checkOutput("abort frame start seen", txB, 1'b0);
        repeat (4 * BAUD_DIV + 6) @(negedge clock);
        checkOutput("abort frame bit3 low", txB, 1'b0);
        gap = doneCntB;
        reset = 1'b1;
        #1;
        checkOutput("mid-frame reset tx", txB, 1'b1);
        checkOutput("mid-frame reset ready", readyB, 1'b1);
        checkOutput("mid-frame reset busy", busyB, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 3 * BAUD_DIV; c++) begin
            if (txB !== 1'b1 || busyB !== 1'b0) bad++;
            @(negedge clock);
        end
        checkInt("aborted frame resumed cycles", bad, 0);
        checkInt("aborted frame done pulses", doneCntB - gap, 0);
        sendFrame(1, 8'h3C, 1'b1);

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
